// File: rtl/rs_pkg.sv
// ============================================================================
// Module   : rs_pkg
// Purpose  : Shared GF(2^m) helpers, FSM state type and parameter checks for
//            the streaming Reed-Solomon decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_pkg;

    localparam int GF_MAX_W = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SOLVE   = 2'd1,
        EMIT    = 2'd2
    } rs_state_t;

    // Shift-and-add multiply, reducing by the primitive polynomial as we go.
    function automatic logic [GF_MAX_W-1:0] gf_mul(
        input logic [GF_MAX_W-1:0] a,
        input logic [GF_MAX_W-1:0] b,
        input int                  w,
        input logic [GF_MAX_W:0]   poly
    );
        logic [GF_MAX_W:0]   aa;
        logic [GF_MAX_W-1:0] p;
        aa = {1'b0, a};
        p  = '0;
        for (int i = 0; i < GF_MAX_W; i++) begin
            if (i < w) begin
                if (b[i]) begin
                    p = p ^ aa[GF_MAX_W-1:0];
                end
                aa = aa << 1;
                if (aa[w]) begin
                    aa = aa ^ poly;
                end
            end
        end
        return p;
    endfunction

    function automatic logic [GF_MAX_W-1:0] gf_alog(
        input int                k,
        input int                w,
        input logic [GF_MAX_W:0] poly
    );
        logic [GF_MAX_W-1:0] v;
        v = GF_MAX_W'(1);
        for (int i = 0; i < (1 << GF_MAX_W); i++) begin
            if (i < k) begin
                v = gf_mul(v, GF_MAX_W'(2), w, poly);
            end
        end
        return v;
    endfunction

    // log(0) is undefined; it maps to 0 and the solver never consumes it.
    function automatic logic [GF_MAX_W-1:0] gf_log(
        input logic [GF_MAX_W-1:0] val,
        input int                  w,
        input logic [GF_MAX_W:0]   poly
    );
        logic [GF_MAX_W-1:0] v;
        logic [GF_MAX_W-1:0] res;
        v   = GF_MAX_W'(1);
        res = '0;
        for (int k = (1 << GF_MAX_W) - 2; k >= 0; k--) begin
            if (k < (1 << w) - 1) begin
                if (gf_alog(k, w, poly) == val) begin
                    res = GF_MAX_W'(k);
                end
            end
        end
        if (v == '0) begin
            res = '0;
        end
        return res;
    endfunction

    function automatic bit rs_params_ok(input int w, input int n, input int cnt_w);
        return (w >= 2) && (w <= GF_MAX_W) && (n == (1 << w) - 1) && (cnt_w >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_syndrome_acc.sv
// ============================================================================
// Module   : rs_syndrome_acc
// Purpose  : Horner accumulator for S1 = r(alpha) and S2 = r(alpha^2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_syndrome_acc
    import rs_pkg::*;
#(
    parameter int                    SYMBOL_WIDTH = 3,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [SYMBOL_WIDTH-1:0] data_i,
    output logic [SYMBOL_WIDTH-1:0] s1_o,
    output logic [SYMBOL_WIDTH-1:0] s2_o
);

    localparam logic [GF_MAX_W:0]   c_poly     = (GF_MAX_W + 1)'(PRIM_POLY);
    localparam logic [GF_MAX_W-1:0] c_alpha1   = gf_alog(1, SYMBOL_WIDTH, c_poly);
    localparam logic [GF_MAX_W-1:0] c_alpha2   = gf_alog(2, SYMBOL_WIDTH, c_poly);

    logic [SYMBOL_WIDTH-1:0] s1_q, s1_d;
    logic [SYMBOL_WIDTH-1:0] s2_q, s2_d;
    logic [GF_MAX_W-1:0]     w_s1_mul, w_s2_mul;

    always_comb begin
        w_s1_mul = gf_mul(GF_MAX_W'(s1_q), c_alpha1, SYMBOL_WIDTH, c_poly);
        w_s2_mul = gf_mul(GF_MAX_W'(s2_q), c_alpha2, SYMBOL_WIDTH, c_poly);
        s1_d     = load_i ? data_i : (w_s1_mul[SYMBOL_WIDTH-1:0] ^ data_i);
        s2_d     = load_i ? data_i : (w_s2_mul[SYMBOL_WIDTH-1:0] ^ data_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (en_i) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign s1_o = s1_q;
    assign s2_o = s2_q;

endmodule

`default_nettype wire

// File: rtl/rs_stream_decoder.sv
// ============================================================================
// Module   : rs_stream_decoder
// Purpose  : Symbol-serial t=1 Reed-Solomon decoder with valid/ready streams.
//            Optional error counter enabled by defining RS_ERR_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_stream_decoder
    import rs_pkg::*;
#(
    parameter int                    SYMBOL_WIDTH = 3,
    parameter int                    N            = 7,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SYMBOL_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SYMBOL_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    out_corrected,
    output logic                    out_uncorrectable
`ifdef RS_ERR_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    err_count
`endif
);

    localparam logic [GF_MAX_W:0]       c_poly  = (GF_MAX_W + 1)'(PRIM_POLY);
    localparam logic [SYMBOL_WIDTH-1:0] c_last  = SYMBOL_WIDTH'(N - 1);
    localparam logic [SYMBOL_WIDTH+1:0] c_n_ext = (SYMBOL_WIDTH + 2)'(N);

    if (!rs_params_ok(SYMBOL_WIDTH, N, CNT_WIDTH)) begin : g_param_err
        $error("rs_stream_decoder: N must equal 2**SYMBOL_WIDTH-1");
    end

    logic [SYMBOL_WIDTH-1:0] w_log_tab  [0:(1 << SYMBOL_WIDTH)-1];
    logic [SYMBOL_WIDTH-1:0] w_alog_tab [0:N-1];

    for (genvar g = 0; g < (1 << SYMBOL_WIDTH); g++) begin : g_log_tab
        localparam logic [GF_MAX_W-1:0] c_entry = gf_log(GF_MAX_W'(g), SYMBOL_WIDTH, c_poly);
        assign w_log_tab[g] = c_entry[SYMBOL_WIDTH-1:0];
    end

    for (genvar g = 0; g < N; g++) begin : g_alog_tab
        localparam logic [GF_MAX_W-1:0] c_entry = gf_alog(g, SYMBOL_WIDTH, c_poly);
        assign w_alog_tab[g] = c_entry[SYMBOL_WIDTH-1:0];
    end

    rs_state_t               state_q, state_d;
    logic [SYMBOL_WIDTH-1:0] cnt_q, cnt_d;
    logic [SYMBOL_WIDTH-1:0] buf_q [0:N-1];
    logic [SYMBOL_WIDTH-1:0] fix_idx_q, err_q;
    logic                    corr_q, uncorr_q;

    logic                    w_acc_en, w_acc_load, w_buf_we, w_solve, w_emit;
    logic [SYMBOL_WIDTH-1:0] w_s1, w_s2;

    rs_syndrome_acc #(
        .SYMBOL_WIDTH (SYMBOL_WIDTH),
        .PRIM_POLY    (PRIM_POLY)
    ) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (w_acc_en),
        .load_i  (w_acc_load),
        .data_i  (in_data),
        .s1_o    (w_s1),
        .s2_o    (w_s2)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_acc_en   = 1'b0;
        w_acc_load = 1'b0;
        w_buf_we   = 1'b0;
        w_solve    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    w_acc_en   = 1'b1;
                    w_acc_load = (cnt_q == '0);
                    w_buf_we   = 1'b1;
                    if (cnt_q == c_last) begin
                        cnt_d   = '0;
                        state_d = SOLVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SOLVE: begin
                w_solve = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (cnt_q == c_last) begin
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = COLLECT;
            end
        endcase
    end

    // Solver in the log domain: pos = log S2 - log S1, err = S1^2 / S2 (mod N).
    logic [SYMBOL_WIDTH-1:0] w_log_s1, w_log_s2, w_pos, w_err, w_fix_idx;
    logic [SYMBOL_WIDTH+1:0] w_pos_sum, w_err_sum;
    logic                    w_s1_nz, w_s2_nz;

    always_comb begin
        w_log_s1  = w_log_tab[w_s1];
        w_log_s2  = w_log_tab[w_s2];
        w_pos_sum = c_n_ext + {2'b00, w_log_s2} - {2'b00, w_log_s1};
        if (w_pos_sum >= c_n_ext) begin
            w_pos_sum = w_pos_sum - c_n_ext;
        end
        w_err_sum = c_n_ext + {1'b0, w_log_s1, 1'b0} - {2'b00, w_log_s2};
        if (w_err_sum >= c_n_ext) begin
            w_err_sum = w_err_sum - c_n_ext;
        end
        if (w_err_sum >= c_n_ext) begin
            w_err_sum = w_err_sum - c_n_ext;
        end
        w_pos     = w_pos_sum[SYMBOL_WIDTH-1:0];
        w_err     = w_alog_tab[w_err_sum[SYMBOL_WIDTH-1:0]];
        w_fix_idx = c_last - w_pos;
        w_s1_nz   = |w_s1;
        w_s2_nz   = |w_s2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            corr_q    <= 1'b0;
            uncorr_q  <= 1'b0;
            fix_idx_q <= '0;
            err_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_solve) begin
                corr_q    <= w_s1_nz & w_s2_nz;
                uncorr_q  <= w_s1_nz ^ w_s2_nz;
                fix_idx_q <= w_fix_idx;
                err_q     <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            buf_q[cnt_q] <= in_data;
        end
    end

`ifdef RS_ERR_COUNT_EN
    logic [CNT_WIDTH-1:0] err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else if (w_solve && w_s1_nz && w_s2_nz && !(&err_count_q)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err_count = err_count_q;
`endif

    assign w_emit            = (state_q == EMIT);
    assign in_ready          = (state_q == COLLECT) && reset_n;
    assign out_valid         = w_emit;
    assign out_last          = w_emit && (cnt_q == c_last);
    assign out_corrected     = w_emit && corr_q;
    assign out_uncorrectable = w_emit && uncorr_q;
    assign out_data          = w_emit ? (buf_q[cnt_q] ^ ((corr_q && (cnt_q == fix_idx_q)) ? err_q : '0))
                                      : '0;

endmodule

`default_nettype wire

// File: tb/tb_rs_stream_decoder.sv
// ============================================================================
// Module   : tb_rs_stream_decoder
// Purpose  : Self-checking bench for rs_stream_decoder against a GF(8) model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_stream_decoder;

    typedef logic [6:0][2:0] word_t;   // index = beat order (position 6-index)

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       out_corrected;
    logic       out_uncorrectable;
`ifdef RS_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    rs_stream_decoder #(
        .SYMBOL_WIDTH (3),
        .N            (7),
        .PRIM_POLY    (4'b1011),
        .CNT_WIDTH    (16)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable)
`ifdef RS_ERR_COUNT_EN
        ,
        .err_count         (err_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model: plain GF(8) polynomial arithmetic ----
    function automatic logic [2:0] tb_mul(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) if (b[i]) p = p ^ ({3'b000, a} << i);
        for (int k = 5; k >= 3; k--) if (p[k]) p = p ^ (6'b001011 << (k - 3));
        return p[2:0];
    endfunction

    function automatic logic [2:0] tb_pow(input int k);
        logic [2:0] v;
        v = 3'd1;
        for (int i = 0; i < k; i++) v = tb_mul(v, 3'd2);
        return v;
    endfunction

    // Generator (x + a)(x + a^2) = x^2 + 6x + 3
    function automatic logic [2:0] gcoef(input int d);
        case (d)
            0:       return 3'd3;
            1:       return 3'd6;
            2:       return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic word_t encode(input logic [14:0] msg_bits);
        word_t      w;
        logic [2:0] acc;
        logic [2:0] mk;
        w = '0;
        for (int j = 0; j < 7; j++) begin
            acc = '0;
            for (int k = 0; k < 5; k++) begin
                mk = msg_bits[3*k +: 3];
                if (j - k >= 0 && j - k <= 2) acc = acc ^ tb_mul(mk, gcoef(j - k));
            end
            w[6-j] = acc;
        end
        return w;
    endfunction

    task automatic model(input word_t rx, output word_t exp, output logic corr, output logic unc);
        logic [2:0] s1, s2, ee;
        int         pp;
        s1 = '0; s2 = '0; ee = '0; pp = 0;
        for (int i = 0; i < 7; i++) begin
            s1 = s1 ^ tb_mul(rx[i], tb_pow(6 - i));
            s2 = s2 ^ tb_mul(rx[i], tb_pow(2 * (6 - i)));
        end
        exp = rx; corr = 1'b0; unc = 1'b0;
        if (s1 != 0 && s2 != 0) begin
            corr = 1'b1;
            for (int p = 0; p < 7; p++) if (tb_mul(s1, tb_pow(p)) == s2) pp = p;
            for (int e = 1; e < 8; e++) if (tb_mul(3'(e), tb_pow(pp)) == s1) ee = 3'(e);
            exp[6-pp] = exp[6-pp] ^ ee;
        end else if (s1 != 0 || s2 != 0) begin
            unc = 1'b1;
        end
    endtask

    // ---------------- stream drivers ----------------------------------------
    task automatic send_word(input word_t w, input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            g = 0;
            in_data  = w[i];
            in_valid = 1'b1;
            while (in_ready !== 1'b1 && g < 40) begin
                @(posedge clk); #1; g++;
            end
            if (in_ready !== 1'b1) begin
                total++; bad++;
                $display("FAIL send_timeout in_ready=%b required=1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic recv_word(output word_t got, output logic corr, output logic unc,
                             output logic last_ok, output logic stable);
        got = '0; corr = 1'b0; unc = 1'b0; last_ok = 1'b1; stable = 1'b1;
        out_ready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            int g;
            g = 0;
            while (out_valid !== 1'b1 && g < 40) begin
                @(posedge clk); #1; g++;
            end
            if (out_valid !== 1'b1) begin
                total++; bad++;
                $display("FAIL recv_timeout beat=%0d out_valid=%b required=1", b, out_valid);
                break;
            end
            got[b] = out_data;
            if (b == 0) begin
                corr = out_corrected; unc = out_uncorrectable;
            end else if (out_corrected !== corr || out_uncorrectable !== unc) begin
                stable = 1'b0;
            end
            if (out_last !== (b == 6)) last_ok = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_last, out_corrected, out_uncorrectable} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=00000",
                     {in_ready, out_valid, out_last, out_corrected, out_uncorrectable});
        end
        total++;
        if (out_data !== 3'd0) begin
            bad++; $display("FAIL reset_data got=%0d required=0", out_data);
        end
`ifdef RS_ERR_COUNT_EN
        total++;
        if (err_count !== 16'd0) begin
            bad++; $display("FAIL reset_errcnt got=%0d required=0", err_count);
        end
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_in_ready got=%b required=1", in_ready);
        end
    endtask

    task automatic test_zero_codeword();
        word_t got; logic c, u, lo, st;
        send_word('0, 7);
        recv_word(got, c, u, lo, st);
        total++;
        if ({got, c, u, lo, st} !== {21'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL zero_cw data=%h corr=%b unc=%b last_ok=%b stable=%b required 0/0/0/1/1",
                     got, c, u, lo, st);
        end
    endtask

    task automatic test_single_pos3();
        word_t rx, got; logic c, u, lo, st;
        rx = '0; rx[3] = 3'b101;
        send_word(rx, 7);
        total++;
        if ({out_valid, in_ready} !== 2'b00) begin
            bad++; $display("FAIL solve_cycle valid/ready=%b required=00", {out_valid, in_ready});
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL first_valid_latency got=%b required=1", out_valid);
        end
        recv_word(got, c, u, lo, st);
        total++;
        if ({got, c, u, lo, st} !== {21'd0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL pos3_fix data=%h corr=%b unc=%b last_ok=%b stable=%b required 0/1/0/1/1",
                     got, c, u, lo, st);
        end
    endtask

    task automatic test_uncorrectable();
        word_t rx, got; logic c, u, lo, st;
        rx = '0; rx[6] = 3'b010; rx[5] = 3'b001;
        send_word(rx, 7);
        recv_word(got, c, u, lo, st);
        total++;
        if ({got, c, u, st} !== {rx, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL uncorrectable data=%h corr=%b unc=%b stable=%b required data=%h 0/1/1",
                     got, c, u, st, rx);
        end
    endtask

    task automatic test_sweep();
        word_t cw, rx, got; logic c, u, lo, st;
        for (int p = 0; p < 7; p++) begin
            for (int v = 1; v < 8; v++) begin
                cw = encode(15'($urandom));
                rx = cw;
                rx[6-p] = rx[6-p] ^ 3'(v);
                send_word(rx, 7);
                recv_word(got, c, u, lo, st);
                total++;
                if ({got, c, u, lo} !== {cw, 1'b1, 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL sweep pos=%0d val=%0d data=%h corr=%b unc=%b required data=%h 1/0",
                             p, v, got, c, u, cw);
                end
            end
        end
    endtask

    task automatic test_random();
        word_t cw, rx, got, exp; logic c, u, lo, st, ec, eu;
        int    ne, p1, p2;
        for (int it = 0; it < 24; it++) begin
            cw = encode(15'($urandom));
            rx = cw;
            ne = $urandom_range(0, 2);
            p1 = $urandom_range(0, 6);
            p2 = (p1 + $urandom_range(1, 6)) % 7;
            if (ne >= 1) rx[p1] = rx[p1] ^ 3'($urandom_range(1, 7));
            if (ne == 2) rx[p2] = rx[p2] ^ 3'($urandom_range(1, 7));
            model(rx, exp, ec, eu);
            send_word(rx, 7);
            recv_word(got, c, u, lo, st);
            total++;
            if ({got, c, u, lo, st} !== {exp, ec, eu, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL random it=%0d nerr=%0d data=%h corr=%b unc=%b required data=%h corr=%b unc=%b",
                         it, ne, got, c, u, exp, ec, eu);
            end
        end
    endtask

    task automatic test_backpressure();
        word_t      cw, rx, got;
        logic [2:0] hd;
        logic       hc, hu;
        cw = encode(15'($urandom));
        rx = cw; rx[2] = rx[2] ^ 3'd6;
        got = '0;
        send_word(rx, 7);
        out_ready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            int g;
            g = 0;
            while (out_valid !== 1'b1 && g < 40) begin
                @(posedge clk); #1; g++;
            end
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_beat beat=%0d valid=%b in_ready=%b required 1/0", b, out_valid, in_ready);
                break;
            end
            got[b] = out_data;
            if (b == 4) begin
                hd = out_data; hc = out_corrected; hu = out_uncorrectable;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    total++;
                    if ({out_valid, out_data, out_corrected, out_uncorrectable, in_ready} !==
                        {1'b1, hd, hc, hu, 1'b0}) begin
                        bad++;
                        $display("FAIL bp_hold cyc=%0d got=%b required=%b", k,
                                 {out_valid, out_data, out_corrected, out_uncorrectable, in_ready},
                                 {1'b1, hd, hc, hu, 1'b0});
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        total++;
        if (got !== cw) begin
            bad++; $display("FAIL bp_data got=%h required=%h", got, cw);
        end
    endtask

    task automatic test_reset_mid();
        word_t cw, rx, got; logic c, u, lo, st;
        send_word(encode(15'($urandom)), 4);
        reset_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid} !== 2'b00) begin
            bad++; $display("FAIL mid_collect_reset ready/valid=%b required=00", {in_ready, out_valid});
        end
`ifdef RS_ERR_COUNT_EN
        total++;
        if (err_count !== 16'd0) begin
            bad++; $display("FAIL errcnt_after_reset got=%0d required=0", err_count);
        end
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        cw = encode(15'($urandom));
        rx = cw; rx[0] = rx[0] ^ 3'd7;
        send_word(rx, 7);
        recv_word(got, c, u, lo, st);
        total++;
        if ({got, c, u} !== {cw, 1'b1, 1'b0}) begin
            bad++; $display("FAIL after_reset data=%h corr=%b unc=%b required data=%h 1/0", got, c, u, cw);
        end
`ifdef RS_ERR_COUNT_EN
        total++;
        if (err_count !== 16'd1) begin
            bad++; $display("FAIL errcnt_one got=%0d required=1", err_count);
        end
`endif
        // Abort during EMIT; the next codeword must come out whole.
        send_word(rx, 7);
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, out_last} !== 5'b0) begin
            bad++; $display("FAIL mid_emit_reset got=%b required=00000", {out_valid, out_data, out_last});
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        cw = encode(15'($urandom));
        rx = cw; rx[6] = rx[6] ^ 3'd1;
        send_word(rx, 7);
        recv_word(got, c, u, lo, st);
        total++;
        if ({got, c, lo} !== {cw, 1'b1, 1'b1}) begin
            bad++; $display("FAIL resume_clean data=%h corr=%b required data=%h corr=1", got, c, cw);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_codeword();
        test_single_pos3();
        test_uncorrectable();
        test_sweep();
        test_random();
        test_backpressure();
        pulse_reset();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
